// File: rtl/nunchuk_pkg.sv
// nunchuk_pkg
// Shared definitions for the nunchuk I2C target:
//   - FSM state encoding (nunchuk_state_e)
//   - default target address, register-file size, init byte pair
//   - register-file type plus helpers to build it and to advance the pointer
// Optional feature macro: NUNCHUK_CLK_STRETCH_EN adds the ST_STRETCH state.
package nunchuk_pkg;

    localparam logic [6:0] NUNCHUK_DEFAULT_ADDR = 7'h52;
    localparam int         NUNCHUK_REG_COUNT    = 6;
    localparam logic [7:0] NUNCHUK_INIT_BYTE0   = 8'hF0;
    localparam logic [7:0] NUNCHUK_INIT_BYTE1   = 8'h55;

    // Encodings are fixed so the debug view is identical with or without
    // the stretch state compiled in.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
`ifdef NUNCHUK_CLK_STRETCH_EN
        ST_STRETCH   = 4'd3,
`endif
        ST_WR_DATA   = 4'd4,
        ST_WR_ACK    = 4'd5,
        ST_RD_DATA   = 4'd6,
        ST_RD_ACK    = 4'd7,
        ST_WAIT_STOP = 4'd8
    } nunchuk_state_e;

    typedef logic [NUNCHUK_REG_COUNT-1:0][7:0] nunchuk_regs_t;

    // Byte 5 packs the accelerometer LSBs and the active-low buttons.
    function automatic nunchuk_regs_t build_regs(
        input logic [7:0] sx,
        input logic [7:0] sy,
        input logic [9:0] ax,
        input logic [9:0] ay,
        input logic [9:0] az,
        input logic       z_btn,
        input logic       c_btn
    );
        nunchuk_regs_t r;
        r[0] = sx;
        r[1] = sy;
        r[2] = ax[9:2];
        r[3] = ay[9:2];
        r[4] = az[9:2];
        r[5] = {az[1:0], ay[1:0], ax[1:0], ~c_btn, ~z_btn};
        return r;
    endfunction

    // Pointer walks 0..5 and wraps; out-of-range pointers stay put.
    function automatic logic [7:0] next_ptr(input logic [7:0] p);
        logic [7:0] n;
        if (p == 8'(NUNCHUK_REG_COUNT - 1)) begin
            n = 8'd0;
        end else if (p < 8'(NUNCHUK_REG_COUNT - 1)) begin
            n = p + 8'd1;
        end else begin
            n = p;
        end
        return n;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync
// Two-flop synchronisers for SCL/SDA plus bus event pulses.
// Ports:
//   clk, rst     system clock, synchronous active-high reset (sync flops -> 1)
//   scl_in       raw SCL level (asynchronous)
//   sda_in       raw SDA level (asynchronous)
//   sda          synchronised SDA level
//   scl_rise     one-cycle pulse on synchronised SCL rising edge
//   scl_fall     one-cycle pulse on synchronised SCL falling edge
//   start_det    one-cycle pulse: SDA fell while SCL stayed high
//   stop_det     one-cycle pulse: SDA rose while SCL stayed high
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;
    logic       scl;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl = scl_sync[1];
    assign sda = sda_sync[1];

    assign scl_rise  = scl & ~scl_d;
    assign scl_fall  = ~scl & scl_d;
    // SCL must be high on both samples so an SDA change racing an SCL
    // edge is never mistaken for START/STOP.
    assign start_det = scl & scl_d & sda_d & ~sda;
    assign stop_det  = scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/nunchuk_responder.sv
// nunchuk_responder
// I2C target emulating a Wii nunchuk: a write sets the register pointer
// (first data byte) and may carry the 0xF0,0x55 init pair; a read returns
// a 6-byte snapshot of the joystick/accelerometer/button inputs.
// Optional feature macro: NUNCHUK_CLK_STRETCH_EN -- hold SCL low for
// STRETCH_CYCLES clk after the read address ACK.
// Parameters:
//   DEV_ADDR        7-bit target address
//   STRETCH_CYCLES  SCL stretch length in clk cycles (stretch build only)
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   scl_in, sda_in            raw bus levels (asynchronous)
//   sda_oe, scl_oe            1 = pull the line low (open drain)
//   stick_x, stick_y          joystick positions
//   accel_x/y/z               accelerometer values
//   z, c                      buttons, 1 = pressed
//   busy                      addressed transfer in progress (match..STOP)
//   xfer_done                 one-cycle pulse on STOP ending an addressed transfer
//   init_seen                 sticky: 0xF0 then 0x55 seen in one write
//   state_dbg                 current FSM state
module nunchuk_responder
    import nunchuk_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = NUNCHUK_DEFAULT_ADDR,
    parameter int unsigned STRETCH_CYCLES = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           scl_in,
    input  logic           sda_in,
    output logic           sda_oe,
    output logic           scl_oe,
    input  logic [7:0]     stick_x,
    input  logic [7:0]     stick_y,
    input  logic [9:0]     accel_x,
    input  logic [9:0]     accel_y,
    input  logic [9:0]     accel_z,
    input  logic           z,
    input  logic           c,
    output logic           busy,
    output logic           xfer_done,
    output logic           init_seen,
    output nunchuk_state_e state_dbg
);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda       (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    nunchuk_state_e state, state_n;
    logic [3:0]     bit_cnt, bit_cnt_n;
    logic [6:0]     shift, shift_n;
    logic           rw, rw_n;
    logic           wr_first, wr_first_n;
    logic           prev_f0, prev_f0_n;
    logic           ack_bit, ack_bit_n;
    logic [7:0]     ptr, ptr_n;
    logic           busy_q, busy_n;
    logic           xfer_done_q, xfer_done_n;
    logic           init_seen_q, init_seen_n;
    logic           sda_oe_q, sda_oe_n;
    logic           snap_en;
    nunchuk_regs_t  regs;
    logic [7:0]     rx_byte;
    logic [7:0]     tx_byte;

`ifdef NUNCHUK_CLK_STRETCH_EN
    localparam int CNT_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRETCH_CYCLES - 1);
    logic             scl_oe_q, scl_oe_n;
    logic [CNT_W-1:0] stretch_cnt, stretch_cnt_n;
`endif

    // Byte being assembled from the bit arriving this cycle.
    assign rx_byte = {shift, sda_s};
    // Pointers past the register file read as all ones.
    assign tx_byte = (ptr < 8'(NUNCHUK_REG_COUNT)) ? regs[ptr[2:0]] : 8'hFF;

    // Next-state / output logic.
    // ACK phases (ADDR_ACK, WR_ACK) are entered on the 8th SCL rise; the
    // following fall starts driving SDA low and the next fall (end of the
    // 9th clock) releases it, so the ACK covers exactly the 9th high period.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        rw_n        = rw;
        wr_first_n  = wr_first;
        prev_f0_n   = prev_f0;
        ack_bit_n   = ack_bit;
        ptr_n       = ptr;
        busy_n      = busy_q;
        xfer_done_n = 1'b0;
        init_seen_n = init_seen_q;
        sda_oe_n    = sda_oe_q;
        snap_en     = 1'b0;
`ifdef NUNCHUK_CLK_STRETCH_EN
        scl_oe_n      = scl_oe_q;
        stretch_cnt_n = stretch_cnt;
`endif

        if (stop_det) begin
            state_n     = ST_IDLE;
            sda_oe_n    = 1'b0;
            busy_n      = 1'b0;
            xfer_done_n = busy_q;
`ifdef NUNCHUK_CLK_STRETCH_EN
            scl_oe_n    = 1'b0;
`endif
        end else if (start_det) begin
            // Repeated START keeps busy and ptr; only the byte framing restarts.
            state_n   = ST_ADDR;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
`ifdef NUNCHUK_CLK_STRETCH_EN
            scl_oe_n  = 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    sda_oe_n = 1'b0;
                end

                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_n   = rx_byte[6:0];
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state_n    = ST_ADDR_ACK;
                                busy_n     = 1'b1;
                                rw_n       = rx_byte[0];
                                wr_first_n = ~rx_byte[0];
                                prev_f0_n  = 1'b0;
                                snap_en    = rx_byte[0];
                            end else begin
                                state_n = ST_WAIT_STOP;
                            end
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            bit_cnt_n = 4'd0;
                            if (rw) begin
                                // First read bit goes out on this fall so it
                                // is already valid if SCL is then stretched.
                                sda_oe_n = ~tx_byte[7];
`ifdef NUNCHUK_CLK_STRETCH_EN
                                state_n       = ST_STRETCH;
                                scl_oe_n      = 1'b1;
                                stretch_cnt_n = '0;
`else
                                state_n       = ST_RD_DATA;
`endif
                            end else begin
                                sda_oe_n = 1'b0;
                                state_n  = ST_WR_DATA;
                            end
                        end
                    end
                end

`ifdef NUNCHUK_CLK_STRETCH_EN
                ST_STRETCH: begin
                    if (stretch_cnt == CNT_LAST) begin
                        scl_oe_n = 1'b0;
                        state_n  = ST_RD_DATA;
                    end else begin
                        stretch_cnt_n = stretch_cnt + 1'b1;
                    end
                end
`endif

                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_n   = rx_byte[6:0];
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state_n    = ST_WR_ACK;
                            wr_first_n = 1'b0;
                            if (wr_first) begin
                                ptr_n = rx_byte;
                            end
                            if (prev_f0 && (rx_byte == NUNCHUK_INIT_BYTE1)) begin
                                init_seen_n = 1'b1;
                            end
                            prev_f0_n = (rx_byte == NUNCHUK_INIT_BYTE0);
                        end
                    end
                end

                ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = 4'd0;
                            state_n   = ST_WR_DATA;
                        end
                    end
                end

                ST_RD_DATA: begin
                    // bit_cnt counts bits already clocked out by SCL rises.
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_n = 1'b0;
                            state_n  = ST_RD_ACK;
                            ptr_n    = next_ptr(ptr);
                        end else begin
                            sda_oe_n = ~tx_byte[3'd7 - bit_cnt[2:0]];
                        end
                    end
                end

                ST_RD_ACK: begin
                    if (scl_rise) begin
                        ack_bit_n = sda_s;
                    end else if (scl_fall) begin
                        if (!ack_bit) begin
                            state_n   = ST_RD_DATA;
                            bit_cnt_n = 4'd0;
                            sda_oe_n  = ~tx_byte[7];
                        end else begin
                            state_n  = ST_WAIT_STOP;
                            sda_oe_n = 1'b0;
                        end
                    end
                end

                ST_WAIT_STOP: begin
                    sda_oe_n = 1'b0;
                end

                default: begin
                    state_n  = ST_IDLE;
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= 4'd0;
            shift       <= 7'd0;
            rw          <= 1'b0;
            wr_first    <= 1'b0;
            prev_f0     <= 1'b0;
            ack_bit     <= 1'b0;
            ptr         <= 8'd0;
            busy_q      <= 1'b0;
            xfer_done_q <= 1'b0;
            init_seen_q <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            rw          <= rw_n;
            wr_first    <= wr_first_n;
            prev_f0     <= prev_f0_n;
            ack_bit     <= ack_bit_n;
            ptr         <= ptr_n;
            busy_q      <= busy_n;
            xfer_done_q <= xfer_done_n;
            init_seen_q <= init_seen_n;
            sda_oe_q    <= sda_oe_n;
        end
    end

    // Snapshot taken at the read address match; later input changes are
    // invisible to the rest of the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else if (snap_en) begin
            regs <= build_regs(stick_x, stick_y, accel_x, accel_y, accel_z, z, c);
        end
    end

`ifdef NUNCHUK_CLK_STRETCH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_oe_q    <= 1'b0;
            stretch_cnt <= '0;
        end else begin
            scl_oe_q    <= scl_oe_n;
            stretch_cnt <= stretch_cnt_n;
        end
    end
    assign scl_oe = scl_oe_q;
`else
    assign scl_oe = 1'b0;
`endif

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign xfer_done = xfer_done_q;
    assign init_seen = init_seen_q;
    assign state_dbg = state;

endmodule

// File: doc/nunchuk_responder.md
NUNCHUK_RESPONDER -- requirements
Module: nunchuk_responder

Interface
REQ-001 Parameter DEV_ADDR, default 7'h52, 7-bit I2C target address answered.
REQ-002 Parameter STRETCH_CYCLES, default 64, clk cycles SCL is held low after a read address ACK (only with NUNCHUK_CLK_STRETCH_EN).
REQ-003 clk  in  1  system clock; one clock only; clk >= 16x SCL rate.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 scl_in  in  1  bus SCL level, asynchronous.
REQ-006 sda_in  in  1  bus SDA level, asynchronous.
REQ-007 sda_oe  out  1  1 = pull SDA low (open-drain), 0 = release.
REQ-008 scl_oe  out  1  1 = pull SCL low (stretch), 0 = release.
REQ-009 stick_x, stick_y  in  8 each  joystick positions.
REQ-010 accel_x, accel_y, accel_z  in  10 each  accelerometer values.
REQ-011 z, c  in  1 each  buttons, 1 = pressed.
REQ-012 busy  out  1  high from an addressed-START match until STOP.
REQ-013 xfer_done  out  1  one-cycle pulse on the STOP that ends an addressed transfer.
REQ-014 init_seen  out  1  sticky; set by write sequence 0xF0,0x55.

Function
REQ-015 scl_in and sda_in shall pass through 2-flop synchronisers; all edge detection uses synchronised values.
REQ-016 START = SDA falling while SCL high; STOP = SDA rising while SCL high; data sampled on SCL rising edge, MSB first.
REQ-017 FSM states: IDLE, ADDR, ADDR_ACK, STRETCH, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-018 IDLE->ADDR on START; ADDR shifts 8 bits; match (addr==DEV_ADDR) -> ADDR_ACK; mismatch -> WAIT_STOP with sda_oe=0 throughout.
REQ-019 sda_oe changes only within 2 clk after a detected SCL falling edge; ACK drives sda_oe=1 for exactly the 9th SCL high period.
REQ-020 Write (R/W=0): first data byte loads ptr; each further byte is ACKed and discarded; every byte ACKed.
REQ-021 Byte sequence 0xF0 followed by 0x55 in one write transfer shall set init_seen.
REQ-022 Read (R/W=1): at the address ACK, all inputs shall be snapshot into the 6-byte register file; later input changes do not affect the transfer.
REQ-023 Register file: b0=stick_x, b1=stick_y, b2=accel_x[9:2], b3=accel_y[9:2], b4=accel_z[9:2], b5={accel_z[1:0],accel_y[1:0],accel_x[1:0],~c,~z}.
REQ-024 RD_DATA shall drive sda_oe=~bit of regfile[ptr] for ptr 0-5, and of 0xFF for ptr>=6; ptr increments after each byte, 5 wraps to 0, ptr>=6 holds.
REQ-025 RD_ACK samples the controller's bit: ACK (0) -> next byte; NACK (1) -> WAIT_STOP, SDA released.
REQ-026 A repeated START in any state shall go to ADDR, keeping ptr; a STOP in any state shall go to IDLE and release both lines.
REQ-027 ptr persists across transfers; written only by a write's first data byte or reset.

Reset
REQ-028 On rst: state=IDLE, sda_oe=0, scl_oe=0, busy=0, xfer_done=0, init_seen=0, ptr=0, regfile=0, synchronisers=1; reset mid-transfer abandons the transfer and releases the bus within 1 clk.

Configuration
REQ-029 With NUNCHUK_CLK_STRETCH_EN defined: after a read address ACK, at SCL falling, scl_oe=1 for STRETCH_CYCLES clk, then released; data shifting starts on the next SCL low.
REQ-030 Without NUNCHUK_CLK_STRETCH_EN: STRETCH state absent, scl_oe tied 0, ADDR_ACK proceeds directly to RD_DATA.

Structure
REQ-031 Shared package nunchuk_pkg: FSM state enum, NUNCHUK_DEFAULT_ADDR=7'h52, NUNCHUK_REG_COUNT=6, init bytes 0xF0/0x55.
REQ-032 One sub-module i2c_bus_sync: synchroniser plus START/STOP/SCL-rise/SCL-fall pulse generation.

Verification
REQ-033 Write 0x52+W, 0xF0, 0x55, STOP -> three ACKs, init_seen=1, xfer_done pulses once.
REQ-034 stick_x=0x80, stick_y=0x7F, z=1, c=0, accel=10'h3FF; write ptr 0x00; read 6 bytes -> 0x80,0x7F,0xFF,0xFF,0xFF,0xFE.
REQ-035 Address 0x53 -> NACK, sda_oe never asserted, busy stays 0.
REQ-036 Read 8 bytes from ptr 4 -> regfile bytes 4,5,0,1,2,3,4,5; change stick_x mid-read -> old value returned.
REQ-037 Assert rst during RD_DATA with sda_oe=1 -> sda_oe=0 next clk, next transfer ACKed normally.
REQ-038 With NUNCHUK_CLK_STRETCH_EN, STRETCH_CYCLES=64 -> scl_oe high exactly 64 clk after read address ACK; byte 0 correct.
